// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard unit: forwarding selects,
// per-stage destination metadata and the register-writer predicate.
package pipe_pkg;

  localparam int unsigned RegBitsDefault = 5;
  // Metadata carries a fixed-width destination so one struct serves any REGBITS up to this.
  localparam int unsigned MetaDstW       = 8;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                valid;
    logic                regwrite;
    logic                memtoreg;
    logic [MetaDstW-1:0] dst;
  } stage_meta_t;

  function automatic logic is_writer(stage_meta_t m);
    return m.valid & m.regwrite & (m.dst != '0);
  endfunction

  // M outranks W so the youngest producer wins.
  function automatic fwd_sel_t fwd_select(logic use_src, logic [MetaDstW-1:0] src,
                                          stage_meta_t m, stage_meta_t w);
    if (use_src && is_writer(m) && (m.dst == src)) return FWD_MEM;
    if (use_src && is_writer(w) && (w.dst == src)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and interlock controller for the 5-stage pipeline: shadow E/M/W metadata,
// E-stage forwarding, W->D bypass, load-use stalls, redirect flushes and perf counters.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int unsigned REGBITS      = RegBitsDefault,
  parameter int unsigned BRANCH_STAGE = 3,
  parameter bit          WB_BYPASS    = 1'b1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_d,
  input  logic [REGBITS-1:0] rs_d,
  input  logic [REGBITS-1:0] rt_d,
  input  logic               use_rs_d,
  input  logic               use_rt_d,
  input  logic               regwrite_d,
  input  logic               memtoreg_d,
  input  logic [REGBITS-1:0] dst_d,
  input  logic               jump_d,
  input  logic               branch_taken,
  output logic               stall_f,
  output logic               stall_d,
  output logic               flush_d,
  output logic               flush_e,
  output logic               flush_m,
  output logic [1:0]         fwd_a_e,
  output logic [1:0]         fwd_b_e,
  output logic               fwd_a_d,
  output logic               fwd_b_d,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  if ((BRANCH_STAGE != 2) && (BRANCH_STAGE != 3)) begin : g_bad_branch_stage
    $error("pipe_hazard_unit: BRANCH_STAGE must be 2 (E) or 3 (M)");
  end
  if ((REGBITS == 0) || (REGBITS > MetaDstW)) begin : g_bad_regbits
    $error("pipe_hazard_unit: REGBITS out of range");
  end

  stage_meta_t meta_e_d, meta_e_q;
  stage_meta_t meta_m_d, meta_m_q;
  stage_meta_t meta_w_d, meta_w_q;

  logic [REGBITS-1:0] rs_e_d, rs_e_q;
  logic [REGBITS-1:0] rt_e_d, rt_e_q;
  logic               use_rs_e_d, use_rs_e_q;
  logic               use_rt_e_d, use_rt_e_q;

  logic [MetaDstW-1:0] rs_d_x, rt_d_x, dst_d_x, rs_e_x, rt_e_x;
  logic                load_use;
  logic                taken;
  logic                stall_w, flush_e_w, flush_m_w;
  fwd_sel_t            fwd_a_sel, fwd_b_sel;

  assign rs_d_x  = MetaDstW'(rs_d);
  assign rt_d_x  = MetaDstW'(rt_d);
  assign dst_d_x = MetaDstW'(dst_d);
  assign rs_e_x  = MetaDstW'(rs_e_q);
  assign rt_e_x  = MetaDstW'(rt_e_q);

  assign taken = branch_taken;

  always_comb begin
    load_use = valid_d & meta_e_q.valid & meta_e_q.memtoreg & is_writer(meta_e_q) &
               ((use_rs_d & (rs_d_x == meta_e_q.dst)) | (use_rt_d & (rt_d_x == meta_e_q.dst)));
  end

  // A taken redirect squashes the stalled consumer anyway, so it overrides the interlock.
  assign stall_w   = load_use & ~taken;
  assign flush_e_w = taken | load_use;
  assign flush_m_w = (BRANCH_STAGE == 3) ? taken : 1'b0;

  assign stall_f = stall_w;
  assign stall_d = stall_w;
  assign flush_d = taken | (jump_d & ~load_use);
  assign flush_e = flush_e_w;
  assign flush_m = flush_m_w;

  always_comb begin
    fwd_a_sel = fwd_select(use_rs_e_q, rs_e_x, meta_m_q, meta_w_q);
    fwd_b_sel = fwd_select(use_rt_e_q, rt_e_x, meta_m_q, meta_w_q);
  end

  assign fwd_a_e = fwd_a_sel;
  assign fwd_b_e = fwd_b_sel;

  if (WB_BYPASS) begin : g_wb_bypass
    assign fwd_a_d = valid_d & use_rs_d & is_writer(meta_w_q) & (meta_w_q.dst == rs_d_x);
    assign fwd_b_d = valid_d & use_rt_d & is_writer(meta_w_q) & (meta_w_q.dst == rt_d_x);
  end else begin : g_no_wb_bypass
    assign fwd_a_d = 1'b0;
    assign fwd_b_d = 1'b0;
  end

  always_comb begin
    meta_w_d = meta_m_q;
    meta_m_d = flush_m_w ? '0 : meta_e_q;

    meta_e_d   = '0;
    rs_e_d     = '0;
    rt_e_d     = '0;
    use_rs_e_d = 1'b0;
    use_rt_e_d = 1'b0;
    if (!flush_e_w) begin
      meta_e_d.valid    = valid_d;
      meta_e_d.regwrite = regwrite_d;
      meta_e_d.memtoreg = memtoreg_d;
      meta_e_d.dst      = dst_d_x;
      rs_e_d            = rs_d;
      rt_e_d            = rt_d;
      use_rs_e_d        = use_rs_d;
      use_rt_e_d        = use_rt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_e_q   <= '0;
      meta_m_q   <= '0;
      meta_w_q   <= '0;
      rs_e_q     <= '0;
      rt_e_q     <= '0;
      use_rs_e_q <= 1'b0;
      use_rt_e_q <= 1'b0;
    end else begin
      meta_e_q   <= meta_e_d;
      meta_m_q   <= meta_m_d;
      meta_w_q   <= meta_w_d;
      rs_e_q     <= rs_e_d;
      rt_e_q     <= rt_e_d;
      use_rs_e_q <= use_rs_e_d;
      use_rt_e_q <= use_rt_e_d;
    end
  end

  // Load flags of M and W are tracked for debug visibility; no hazard depends on them.
  logic unused_meta;
  assign unused_meta = meta_m_q.memtoreg ^ meta_w_q.memtoreg;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc_i  (stall_w),
    .count_o(stall_cnt)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc_i  (taken),
    .count_o(flush_cnt)
  );

endmodule
